ram_backing_store: RTL and testbench

//  Word-wide backing memory with fixed access latency. It sits directly downstream of the
//  4-way cache, on the cache's miss/write-through port.
//  The interface is change-detect plus level response: any change of {data,addr,wr} starts a new access.

---
 rtl/ram_backing_store.sv | 110 +++++++++++
 tb/tb_ram_backing_store.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_backing_store.sv
// Word-wide backing memory with a fixed access latency, fed by a change-detect request
// interface and reporting completion on a level 'response' signal.
module ram_backing_store #(
  parameter int LATENCY = 4,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          resp_q, resp_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   out_q;
  logic          chg;
  logic          mem_we;
  logic          rd_done;

  logic [31:0] mem [0:(1<<AW)-1];

  // primed_q forces the first edge after reset to start an access even if inputs match the cleared shadows
  assign chg = !primed_q || (data != data_q) || (addr != addr_q) || (wr != wr_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    resp_d   = resp_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    mem_we   = 1'b0;
    rd_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (chg) begin
          data_d   = data;
          addr_d   = addr;
          wr_d     = wr;
          primed_d = 1'b1;
          cnt_d    = CNT_LOAD;
          resp_d   = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (chg) begin
          // A change always wins, even on the completing edge: the old access is dropped uncommitted.
          data_d = data;
          addr_d = addr;
          wr_d   = wr;
          cnt_d  = CNT_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          resp_d  = 1'b1;
          state_d = IDLE;
          mem_we  = wr_q;
          rd_done = !wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      resp_q   <= 1'b1;
      data_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      resp_q   <= resp_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      if (rd_done) out_q <= mem[addr_q[AW-1:0]];
    end
  end

  // Array is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= data_q;
  end

  assign response = resp_q;
  assign out      = out_q;

endmodule

// File: tb/tb_ram_backing_store.sv
// Directed bench for ram_backing_store: latency, read-back, abort, aliasing and reset mid-access.
module tb_ram_backing_store;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  ram_backing_store #(.LATENCY(4), .AW(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
    .response (response),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts low cycles of response (sampled on negedges) until it returns high; bounded.
  task automatic wait_done(input string tag);
    int lowc;
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (response === 1'b1) break;
      lowc++;
    end
    chk({tag, "_lat"}, 32'(lowc), 32'd4);
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
    @(negedge clk);
    wr = w; addr = a; data = d;
    wait_done(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    wr    = $urandom_range(0, 1);
    addr  = $urandom;
    data  = $urandom;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_async", {31'd0, response}, 32'd1);
    chk("rst_out_async", out, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_resp_held", {31'd0, response}, 32'd1);

    // Write 5 released straight out of reset (first edge starts the access).
    wr = 1'b1; addr = 32'd5; data = 32'hDEADBEEF;
    rst_n = 1'b1;
    wait_done("wr5");
    chk("wr5_out_unchanged", out, 32'd0);

    // Idle with constant inputs: no new access.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold", {31'd0, response}, 32'd1);
    end

    do_access(1'b0, 32'd5, 32'hDEADBEEF, "rd5");
    chk("rd5_out", out, 32'hDEADBEEF);

    // Seed known contents.
    do_access(1'b1, 32'd7, 32'h7777_0000, "wr7");
    do_access(1'b1, 32'd9, 32'h9999_0000, "wr9");
    do_access(1'b1, 32'd0, 32'h1234_5678, "wr0");
    chk("wr_out_unchanged", out, 32'hDEADBEEF);

    // Abort: write 7 replaced by write 8 two cycles in.
    @(negedge clk);
    wr = 1'b1; addr = 32'd7; data = 32'h1111_1111;
    @(negedge clk);
    chk("abort_busy", {31'd0, response}, 32'd0);
    @(negedge clk);
    addr = 32'd8;
    wait_done("abort");
    do_access(1'b0, 32'd7, 32'd0, "rd7_after_abort");
    chk("rd7_after_abort", out, 32'h7777_0000);
    do_access(1'b0, 32'd8, 32'd0, "rd8");
    chk("rd8", out, 32'h1111_1111);

    // Change on the same edge where cnt reaches zero: the write to 7 is dropped.
    @(negedge clk);
    wr = 1'b1; addr = 32'd7; data = 32'h0000_BBBB;
    repeat (4) @(negedge clk);
    chk("cnt0_busy", {31'd0, response}, 32'd0);
    addr = 32'd20;
    wait_done("cnt0_abort");
    do_access(1'b0, 32'd7, 32'd0, "rd7_cnt0");
    chk("rd7_cnt0", out, 32'h7777_0000);
    do_access(1'b0, 32'd20, 32'd0, "rd20");
    chk("rd20", out, 32'h0000_BBBB);

    // Aliasing: 0x405 maps to word 5.
    do_access(1'b1, 32'h405, 32'hCAFE0001, "wr405");
    do_access(1'b0, 32'd5, 32'd0, "rd5_alias");
    chk("rd5_alias", out, 32'hCAFE0001);

    // Reset when cnt==1 of a write to 9.
    @(negedge clk);
    wr = 1'b1; addr = 32'd9; data = 32'h0000_AAAA;
    repeat (3) @(negedge clk);
    chk("midrst_busy", {31'd0, response}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp", {31'd0, response}, 32'd1);
    chk("midrst_out", out, 32'd0);
    wr = 1'b0; addr = 32'd0; data = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    // Inputs equal the cleared shadows; only the primed path can start this read.
    wait_done("primed_rd0");
    chk("primed_rd0", out, 32'h1234_5678);
    do_access(1'b0, 32'd9, 32'd0, "rd9_after_rst");
    chk("rd9_after_rst", out, 32'h9999_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
